// File: rtl/encoder_pkg.sv
// Shared definitions for the encoder controller: register map, CTRL/STATUS
// bit positions, FSM encoding and the captured sample layout.
package encoder_pkg;

  localparam logic [2:0] REG_CTRL       = 3'd0;
  localparam logic [2:0] REG_PERIOD     = 3'd1;
  localparam logic [2:0] REG_STATUS     = 3'd2;
  localparam logic [2:0] REG_POP        = 3'd3;
  localparam logic [2:0] REG_SHADOW_VEL = 3'd4;
  localparam logic [2:0] REG_SHADOW_DIR = 3'd5;
  localparam logic [2:0] REG_LIVE_POS   = 3'd6;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_SAMPLE_EN = 1;
  localparam int CTRL_IRQ_EN    = 2;
  localparam int CTRL_CLEAR     = 3;

  localparam int STAT_EMPTY     = 8;
  localparam int STAT_FULL      = 9;
  localparam int STAT_OVERFLOW  = 10;
  localparam int STAT_STATE_LSB = 11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam int SAMPLE_W = 65;

  typedef struct packed {
    logic [31:0] pos;
    logic [31:0] vel;
    logic        dir;
  } sample_t;

  // Interval timer reload value; a PERIOD of 0 behaves as 1.
  function automatic logic [31:0] period_reload(input logic [31:0] period);
    return (period == 32'd0) ? 32'd0 : period - 32'd1;
  endfunction

endpackage

// File: rtl/enc_sample_fifo.sv
// Synchronous sample FIFO with flush and same-cycle push/pop (also when full).
module enc_sample_fifo
  import encoder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_level == LVL_FULL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // A pop frees the slot, so a push into a full FIFO is fine in the same cycle.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/encoder_ctrl.sv
// Encoder controller: register bus front-end, run/clear sequencing of the
// encoder_core and periodic snapshot capture into the sample FIFO.
//   state | meaning
//   IDLE  | core disabled, interval timer holds
//   RUN   | core enabled, timer counts when sample_en
//   CLEAR | core in reset; FIFO, timer, shadows, overflow flushed
module encoder_ctrl
  import encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CLR_CYCLES = 2,
  parameter int PERIOD_RST = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        core_enable,
  output logic        core_reset,
  input  logic [31:0] core_position,
  input  logic [31:0] core_velocity,
  input  logic        core_direction,
  output logic        irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  logic [1:0]    r_state;
  logic [CW-1:0] r_clr_cnt;
  logic          r_enable;
  logic          r_sample_en;
  logic          r_irq_en;
  logic [31:0]   r_period;
  logic [31:0]   r_tmr;
  logic          r_overflow;
  logic [31:0]   r_shadow_vel;
  logic          r_shadow_dir;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic          r_irq;

  logic          w_accept;
  logic          w_wr;
  logic          w_rd;
  logic          w_wr_ctrl;
  logic          w_clear;
  logic          w_wr_period;
  logic          w_ovf_clr;
  logic          w_in_clear;
  logic          w_sampling;
  logic          w_capture;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;
  sample_t       w_sample;
  sample_t       w_head;
  logic [31:0]   w_rdata;

  assign req_ready   = !r_rsp_valid;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign irq         = r_irq;
  assign core_enable = (r_state == ST_RUN);
  assign core_reset  = reset || w_in_clear;

  assign w_accept    = req_valid && !r_rsp_valid;
  assign w_wr        = w_accept && req_write;
  assign w_rd        = w_accept && !req_write;
  assign w_wr_ctrl   = w_wr && (req_addr == REG_CTRL);
  assign w_clear     = w_wr_ctrl && req_wdata[CTRL_CLEAR];
  assign w_wr_period = w_wr && (req_addr == REG_PERIOD);
  assign w_ovf_clr   = w_wr && (req_addr == REG_STATUS) && req_wdata[STAT_OVERFLOW];
  assign w_in_clear  = (r_state == ST_CLEAR);
  assign w_sampling  = (r_state == ST_RUN) && r_sample_en;

  // A PERIOD write restarts the interval, so it also suppresses that cycle's capture.
  assign w_capture   = w_sampling && (r_tmr == 32'd0) && !w_wr_period;
  assign w_pop       = w_rd && (req_addr == REG_POP) && !w_empty;
  assign w_drop      = w_capture && w_full && !w_pop;
  assign w_sample    = {core_position, core_velocity, core_direction};

  enc_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_in_clear),
    .i_push  (w_capture),
    .i_pop   (w_pop),
    .i_wdata (w_sample),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_clr_cnt <= '0;
    end else if (w_clear) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= CW'(CLR_CYCLES - 1);
    end else begin
      case (r_state)
        ST_IDLE:  if (r_enable) r_state <= ST_RUN;
        ST_RUN:   if (!r_enable) r_state <= ST_IDLE;
        ST_CLEAR: begin
          if (r_clr_cnt == '0) r_state <= r_enable ? ST_RUN : ST_IDLE;
          else                 r_clr_cnt <= r_clr_cnt - 1'b1;
        end
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enable    <= 1'b0;
      r_sample_en <= 1'b0;
      r_irq_en    <= 1'b0;
      r_period    <= 32'(PERIOD_RST);
    end else begin
      if (w_wr_ctrl) begin
        r_enable    <= req_wdata[CTRL_ENABLE];
        r_sample_en <= req_wdata[CTRL_SAMPLE_EN];
        r_irq_en    <= req_wdata[CTRL_IRQ_EN];
      end
      if (w_wr_period) r_period <= req_wdata;
    end
  end

  // Down-counting interval timer; capture on terminal count, then reload.
  always_ff @(posedge clk) begin
    if (reset)            r_tmr <= period_reload(32'(PERIOD_RST));
    else if (w_wr_period) r_tmr <= period_reload(req_wdata);
    else if (w_in_clear)  r_tmr <= period_reload(r_period);
    else if (w_sampling)  r_tmr <= (r_tmr == 32'd0) ? period_reload(r_period) : r_tmr - 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || w_in_clear) begin
      r_overflow   <= 1'b0;
      r_shadow_vel <= 32'd0;
      r_shadow_dir <= 1'b0;
    end else begin
      if (w_drop)         r_overflow <= 1'b1;
      else if (w_ovf_clr) r_overflow <= 1'b0;
      if (w_pop) begin
        r_shadow_vel <= w_head.vel;
        r_shadow_dir <= w_head.dir;
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (req_addr)
      REG_CTRL: begin
        w_rdata[CTRL_ENABLE]    = r_enable;
        w_rdata[CTRL_SAMPLE_EN] = r_sample_en;
        w_rdata[CTRL_IRQ_EN]    = r_irq_en;
      end
      REG_PERIOD: w_rdata = r_period;
      REG_STATUS: begin
        w_rdata[7:0]                 = 8'(w_level);
        w_rdata[STAT_EMPTY]          = w_empty;
        w_rdata[STAT_FULL]           = w_full;
        w_rdata[STAT_OVERFLOW]       = r_overflow;
        w_rdata[STAT_STATE_LSB +: 2] = r_state;
      end
      REG_POP:        w_rdata = w_empty ? 32'd0 : w_head.pos;
      REG_SHADOW_VEL: w_rdata = r_shadow_vel;
      REG_SHADOW_DIR: w_rdata[0] = r_shadow_dir;
      REG_LIVE_POS:   w_rdata = core_position;
      default:        w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_irq       <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_rdata <= w_rd ? w_rdata : 32'd0;
      r_irq       <= r_irq_en && (!w_empty || r_overflow);
    end
  end

endmodule

// File: tb/tb_encoder_ctrl.sv
// Self-checking bench for encoder_ctrl: directed scenarios plus randomized bus
// traffic, checked every cycle against a queue-based behavioural model.
module tb_encoder_ctrl;
  localparam int DEPTH = 8;
  localparam int CLR   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        core_enable;
  logic        core_reset;
  logic [31:0] core_position;
  logic [31:0] core_velocity;
  logic        core_direction;
  logic        irq;

  int checks = 0;
  int errors = 0;

  encoder_ctrl #(.FIFO_DEPTH(DEPTH), .CLR_CYCLES(CLR), .PERIOD_RST(1000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .core_enable(core_enable), .core_reset(core_reset),
    .core_position(core_position), .core_velocity(core_velocity),
    .core_direction(core_direction), .irq(irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct { logic [31:0] p; logic [31:0] v; logic d; } smp_t;
  smp_t        q[$];
  bit          m_init = 0;
  int          m_state;      // 0 IDLE, 1 RUN, 2 CLEAR
  int          m_clr_left;
  bit          m_en, m_sen, m_ien, m_ovf, m_sdir, m_irq, m_rspv;
  logic [31:0] m_period, m_svel, m_rdata;
  longint      m_cnt;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r = {29'd0, m_ien, m_sen, m_en};
      3'd1: r = m_period;
      3'd2: begin
        r[7:0]   = 8'(q.size());
        r[8]     = (q.size() == 0);
        r[9]     = (q.size() == DEPTH);
        r[10]    = m_ovf;
        r[12:11] = 2'(m_state);
      end
      3'd3: r = (q.size() != 0) ? q[0].p : 32'd0;
      3'd4: r = m_svel;
      3'd5: r = {31'd0, m_sdir};
      3'd6: r = core_position;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_step();
    bit acc, wr, rd, cap, popd, irq_n, en_old;
    longint pe;
    logic [31:0] rv;
    smp_t s;
    if (reset) begin
      m_init = 1; m_state = 0; m_clr_left = 0;
      m_en = 0; m_sen = 0; m_ien = 0; m_ovf = 0; m_sdir = 0; m_irq = 0; m_rspv = 0;
      m_period = 32'd1000; m_svel = 0; m_rdata = 0; m_cnt = 0;
      q.delete();
      return;
    end
    acc   = req_valid && !m_rspv;
    wr    = acc && req_write;
    rd    = acc && !req_write;
    rv    = model_read(req_addr);
    pe    = (m_period == 0) ? 1 : longint'(m_period);
    cap   = (m_state == 1) && m_sen && !(wr && req_addr == 3'd1) && (m_cnt == pe - 1);
    popd  = rd && req_addr == 3'd3 && q.size() != 0;
    irq_n = m_ien && (q.size() != 0 || m_ovf);
    if (m_state == 2) begin
      q.delete(); m_cnt = 0; m_svel = 0; m_sdir = 0; m_ovf = 0;
    end else begin
      if (popd) begin
        s = q.pop_front();
        m_svel = s.v; m_sdir = s.d;
      end
      if (wr && req_addr == 3'd2 && req_wdata[10]) m_ovf = 0;
      if (cap) begin
        if (q.size() < DEPTH) begin
          s.p = core_position; s.v = core_velocity; s.d = core_direction;
          q.push_back(s);
        end else m_ovf = 1;
      end
      if (wr && req_addr == 3'd1) m_cnt = 0;
      else if (m_state == 1 && m_sen) m_cnt = cap ? 0 : m_cnt + 1;
    end
    if (wr && req_addr == 3'd1) m_period = req_wdata;
    en_old = m_en;
    if (wr && req_addr == 3'd0) begin
      m_en = req_wdata[0]; m_sen = req_wdata[1]; m_ien = req_wdata[2];
    end
    if (wr && req_addr == 3'd0 && req_wdata[3]) begin
      m_state = 2; m_clr_left = CLR;
    end else if (m_state == 0) begin
      if (en_old) m_state = 1;
    end else if (m_state == 1) begin
      if (!en_old) m_state = 0;
    end else begin
      m_clr_left--;
      if (m_clr_left == 0) m_state = en_old ? 1 : 0;
    end
    m_irq  = irq_n;
    m_rspv = acc;
    m_rdata = rd ? rv : 32'd0;
  endtask

  always @(posedge clk) model_step();

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (m_init) begin
      chk("rsp_valid",   32'(rsp_valid),   32'(m_rspv));
      chk("rsp_rdata",   rsp_rdata,        m_rdata);
      chk("req_ready",   32'(req_ready),   32'(!m_rspv));
      chk("irq",         32'(irq),         32'(m_irq));
      chk("core_enable", 32'(core_enable), 32'(m_state == 1));
      chk("core_reset",  32'(core_reset),  32'(reset || m_state == 2));
    end
  end

  int rst_hi = 0;
  always @(negedge clk) if (core_reset && !reset) rst_hi++;

  // ---------------- core input driver ----------------
  bit          hold = 1;
  logic [31:0] hold_pos = 32'd5;
  logic [31:0] hold_vel = 32'hFFFF_FFF9;
  always @(negedge clk) begin
    if (hold) begin
      core_position = hold_pos; core_velocity = hold_vel; core_direction = 1'b1;
    end else begin
      core_position = $urandom(); core_velocity = $urandom();
      core_direction = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- bus helpers ----------------
  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    @(negedge clk);
    chk("bus_rsp", 32'(rsp_valid), 32'd1);
    rd = rsp_rdata;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, a, d, dummy);
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    bus_xfer(1'b0, a, 32'd0, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    int snap;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 3'd0; req_wdata = 32'd0;
    core_position = 32'd5; core_velocity = 32'hFFFF_FFF9; core_direction = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_core_enable", 32'(core_enable), 32'd0);
    bus_rd(3'd2, rd); chk("rst_status", rd, 32'h100);
    bus_rd(3'd1, rd); chk("rst_period", rd, 32'd1000);
    bus_rd(3'd0, rd); chk("rst_ctrl", rd, 32'd0);

    // Periodic capture of a held position
    bus_wr(3'd1, 32'd10);
    bus_wr(3'd0, 32'h3);
    repeat (33) @(negedge clk);
    chk("model_level3", 32'(q.size()), 32'd3);
    bus_rd(3'd2, rd); chk("p10_status", rd, 32'h803);
    bus_rd(3'd3, rd); chk("p10_pop", rd, 32'd5);
    bus_rd(3'd4, rd); chk("p10_shadow_vel", rd, 32'hFFFF_FFF9);
    bus_rd(3'd5, rd); chk("p10_shadow_dir", rd, 32'd1);
    bus_rd(3'd6, rd); chk("live_pos", rd, 32'd5);

    // Soft clear while running
    snap = rst_hi;
    bus_wr(3'd0, 32'h9);
    chk("clr_core_reset", 32'(core_reset), 32'd1);
    chk("clr_core_enable", 32'(core_enable), 32'd0);
    @(negedge clk);
    chk("clr_exit_reset", 32'(core_reset), 32'd0);
    chk("clr_exit_run", 32'(core_enable), 32'd1);
    repeat (2) @(negedge clk);
    chk("clr_width", 32'(rst_hi - snap), 32'd2);
    bus_rd(3'd2, rd); chk("clr_status", rd, 32'h900);

    // Fill to full, overflow, clear overflow
    hold = 0;
    bus_wr(3'd1, 32'd1);
    bus_wr(3'd0, 32'h3);
    repeat (12) @(negedge clk);
    bus_wr(3'd0, 32'h1);
    chk("model_full", 32'(q.size()), 32'd8);
    bus_rd(3'd2, rd); chk("full_ovf_status", rd, 32'hE08);
    bus_wr(3'd2, 32'h400);
    bus_rd(3'd2, rd); chk("ovf_cleared", rd, 32'hA08);

    // Capture and pop in the same cycle while full
    bus_wr(3'd1, 32'd3);
    bus_wr(3'd0, 32'h3);
    @(negedge clk);
    bus_rd(3'd3, rd);
    bus_wr(3'd0, 32'h1);
    bus_rd(3'd2, rd); chk("cap_pop_full", rd, 32'hA08);

    // Interrupt behaviour
    bus_wr(3'd0, 32'h9);
    repeat (3) @(negedge clk);
    bus_wr(3'd1, 32'd5);
    bus_wr(3'd0, 32'h7);
    for (int i = 0; i < 40 && !irq; i++) @(negedge clk);
    chk("irq_rise", 32'(irq), 32'd1);
    bus_wr(3'd0, 32'h5);
    bus_rd(3'd2, rd); chk("irq_level1", rd, 32'h801);
    bus_rd(3'd3, rd);
    @(negedge clk);
    chk("irq_fall", 32'(irq), 32'd0);
    bus_rd(3'd3, rd); chk("pop_empty", rd, 32'd0);
    bus_rd(3'd2, rd); chk("pop_empty_status", rd, 32'h900);

    // Randomized traffic with occasional mid-transaction resets
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 3'($urandom_range(0, 7));
      case (req_addr)
        3'd0:    req_wdata = {28'd0, ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7))};
        3'd1:    req_wdata = 32'($urandom_range(0, 6));
        default: req_wdata = $urandom();
      endcase
      @(negedge clk);
    end
    reset = 1'b0; req_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
